ifu_fetch: RTL and testbench

Instruction fetch unit for the MIPS core. It holds the PC and issues one request at a time to an external instruction memory with variable latency. It presents the fetched instruction to the decode/controller stage, which splits it into opcode and funct. On the datapath's advance strobe it computes the next PC from the controller's 2-bit NPC operation code and loads it.

---
 rtl/ifu_fetch_pkg.sv | 9 +
 rtl/ifu_fetch_npc_calc.sv | 24 ++
 rtl/ifu_fetch.sv | 68 ++++++
 tb/tb_ifu_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: next-PC operation codes, reset PC and fetch FSM encoding
package ifu_fetch_pkg;
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  typedef enum logic [1:0] {FETCH, READY, HALT} state_t;
endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// ifu_fetch_npc_calc: combinational next-PC selection with misalignment detect
module ifu_fetch_npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_eq,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] npc,
  output logic        misaligned
);
  logic [31:0] seq;
  logic [31:0] br;
  always_comb begin
    seq = pc + 32'd4;
    br = seq + {{14{imm16[15]}}, imm16, 2'b00};
    npc = npc_op == NPC_JR  ? rs_val :
          npc_op == NPC_JAL ? {pc[31:28], imm26, 2'b00} :
          (npc_op == NPC_BEQ && br_eq) ? br : seq;
    misaligned = |npc[1:0];
  end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register and single-outstanding instruction fetch FSM
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         npc_op,
  input  logic               br_eq,
  input  logic [15:0]        imm16,
  input  logic [25:0]        imm26,
  input  logic [31:0]        rs_val,
  input  logic               advance,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_err
);
  state_t state;
  logic [31:0] npc;
  logic misaligned;
  ifu_fetch_npc_calc npc_calc (
    .pc(pc), .npc_op(npc_op), .br_eq(br_eq), .imm16(imm16),
    .imm26(imm26), .rs_val(rs_val), .npc(npc), .misaligned(misaligned)
  );
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW-1:0];
  // imem_req is a flop mirroring state==FETCH, so it leaves reset already high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= PC_RESET;
      instr <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b1;
      fetch_err <= 1'b0;
    end else
      case (state)
        FETCH: if (imem_rvalid) begin
          instr <= imem_rdata;
          instr_valid <= 1'b1;
          imem_req <= 1'b0;
          state <= READY;
        end
        READY: if (advance) begin
          instr_valid <= 1'b0;
          if (misaligned) begin
            fetch_err <= 1'b1;
            state <= HALT;
          end else begin
            pc <= npc;
            imem_req <= 1'b1;
            state <= FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed fetch/next-PC vectors checked against a flag-level reference model
module tb_ifu_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] npc_op = '0;
  logic br_eq = 1'b0, advance = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] rs_val = '0;
  logic imem_req, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4;
  logic instr_valid, fetch_err;
  int total = 0, bad = 0, lat = 0, cnt = 0;
  bit spur = 1'b0;

  ifu_fetch #(.PC_RESET(32'h0000_3000), .IMEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .br_eq(br_eq), .imm16(imm16),
    .imm26(imm26), .rs_val(rs_val), .advance(advance), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [1:0] op, input logic eq,
                                          input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
    int off = int'($signed(i16)) * 4;
    case (op)
      2'd0: return p + 32'd4;
      2'd1: return eq ? p + 32'd4 + 32'(off) : p + 32'd4;
      2'd2: return (p & 32'hF000_0000) + {6'd0, i26} * 32'd4;
      default: return rs;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: responds lat+1 cycles after seeing req, or injects a stray pulse on request
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      imem_rvalid = 1'b0;
      cnt = 0;
    end else if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      cnt = 0;
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      spur = 1'b0;
    end else if (imem_req) begin
      if (cnt == lat + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else cnt++;
    end

  logic [31:0] m_pc, m_instr;
  logic m_valid, m_err;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pc <= 32'h0000_3000;
      m_instr <= '0;
      m_valid <= 1'b0;
      m_err <= 1'b0;
    end else if (!m_err) begin
      if (m_valid && advance) begin
        m_valid <= 1'b0;
        if (next_pc(m_pc, npc_op, br_eq, imm16, imm26, rs_val) % 4 != 0) m_err <= 1'b1;
        else m_pc <= next_pc(m_pc, npc_op, br_eq, imm16, imm26, rs_val);
      end else if (!m_valid && imem_rvalid) begin
        m_valid <= 1'b1;
        m_instr <= imem_rdata;
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("imem_req", 32'(imem_req), 32'(!m_valid && !m_err));
      chk("instr", instr, m_instr);
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
    end

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: instr_valid still 0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic retire(input logic [1:0] op, input logic eq, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] rs, input logic [31:0] exp_pc, input string name);
    int n;
    wait_valid(n);
    npc_op = op; br_eq = eq; imm16 = i16; imm26 = i26; rs_val = rs; advance = 1'b1;
    @(negedge clk);
    advance = 1'b0; npc_op = 2'b11; rs_val = 32'h0000_0002; br_eq = 1'b1; imm16 = 16'h8001;
    chk(name, pc, exp_pc);
  endtask

  initial begin
    int n;
    logic [31:0] seq_pc [5] = '{32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
    #7;
    chk("rst pc", pc, 32'h3000);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_valid", 32'(instr_valid), 32'h0);
    chk("rst fetch_err", 32'(fetch_err), 32'h0);
    chk("rst imem_addr", imem_addr, 32'h3000);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first imem_addr", imem_addr, 32'h3000);
    wait_valid(n);
    chk("first fetch latency", 32'(n), 32'd2);
    chk("first instr", instr, mem_word(32'h3000));
    for (int i = 0; i < 5; i++) retire(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, seq_pc[i], "seq pc");
    retire(2'b11, 1'b0, 16'h0, 26'h0, 32'h3010, 32'h3010, "jr 3010");
    retire(2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h300C, "beq taken");
    retire(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3010, "seq pc");
    retire(2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h3014, "beq not taken");
    retire(2'b11, 1'b0, 16'h0, 26'h0, 32'h3010, 32'h3010, "jr 3010");
    wait_valid(n);
    chk("pc_plus4 at jal", pc_plus4, 32'h3014);
    retire(2'b10, 1'b0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, "jal");
    lat = 5;
    retire(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3044, "seq pc slow");
    for (int i = 0; i < 6; i++) begin
      chk("slow req", 32'(imem_req), 32'h1);
      chk("slow addr", imem_addr, 32'h3044);
      chk("slow valid", 32'(instr_valid), 32'h0);
      @(negedge clk);
    end
    wait_valid(n);
    chk("slow instr", instr, mem_word(32'h3044));
    #1 spur = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("spurious instr", instr, mem_word(32'h3044));
    chk("spurious valid", 32'(instr_valid), 32'h1);
    lat = 1;
    retire(2'b11, 1'b0, 16'h0, 26'h0, 32'h3100, 32'h3100, "jr 3100");
    retire(2'b11, 1'b0, 16'h0, 26'h0, 32'h3102, 32'h3100, "jr misaligned pc");
    for (int i = 0; i < 5; i++) begin
      chk("halt err", 32'(fetch_err), 32'h1);
      chk("halt req", 32'(imem_req), 32'h0);
      chk("halt pc", pc, 32'h3100);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk("halt rst err", 32'(fetch_err), 32'h0);
    chk("halt rst pc", pc, 32'h3000);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    lat = 3;
    for (int i = 1; i <= 8; i++) retire(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3000 + 32'(4 * i), "seq pc");
    chk("pre-reset addr", imem_addr, 32'h3020);
    #2 rst_n = 1'b0;
    #1 chk("mid rst pc", pc, 32'h3000);
    chk("mid rst valid", 32'(instr_valid), 32'h0);
    chk("mid rst instr", instr, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("restart addr", imem_addr, 32'h3000);
    wait_valid(n);
    chk("restart instr", instr, mem_word(32'h3000));
    chk("restart pc", pc, 32'h3000);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
